// File: rtl/sha3_job_sched_if.sv
// Handshake bundle between the job scheduler and its environment:
// requester front ends, the Keccak core and the output serializer.
interface sha3_job_sched_if #(
  parameter int N_REQ = 2
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]   req_valid;
  logic [2*N_REQ-1:0] req_tuser;
  logic [N_REQ-1:0]   req_lite;
  logic [N_REQ-1:0]   req_ready;
  logic               core_start;
  logic               core_done;
  logic               out_ready;
  logic [1:0]         out_tuser;
  logic               out_mode;
  logic               out_last;
  logic [ID_W-1:0]    out_id;
  logic [N_REQ-1:0]   done;
  logic [N_REQ-1:0]   err;
  logic               busy;

  // scheduler side
  modport master (
    input  req_valid, req_tuser, req_lite, core_done, out_last,
    output req_ready, core_start, out_ready, out_tuser, out_mode, out_id,
           done, err, busy
  );

  // environment side (requesters, core, serializer)
  modport slave (
    output req_valid, req_tuser, req_lite, core_done, out_last,
    input  req_ready, core_start, out_ready, out_tuser, out_mode, out_id,
           done, err, busy
  );
endinterface

// File: rtl/sha3_job_sched.sv
// Round-robin job scheduler sharing one Keccak-f[1600] core and its
// output serializer between N_REQ requesters, with a single watchdog
// guarding both the permutation and the drain phase.
//
// state   | meaning
// IDLE    | arbitrate; grant pulses req_ready and latches job attributes
// START   | one-cycle core_start, watchdog loaded with PERM_WAIT
// PERM    | waiting for core_done
// DRAIN   | out_ready held high until out_last
// RELEASE | out_ready low, done/err pulse to owner
module sha3_job_sched #(
  parameter int N_REQ      = 2,
  parameter int DATA_WIDTH = 16,
  parameter int PERM_WAIT  = 32,
  parameter int DRAIN_WAIT = 1600 / DATA_WIDTH + 8
) (
  input logic              ACLK,
  input logic              ARESET,
  sha3_job_sched_if.master bus
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {IDLE, START, PERM, DRAIN, RELEASE} state_t;

  state_t          state, state_nxt;
  logic [15:0]     wd, wd_nxt, wd_dec;
  logic            fail, fail_nxt;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] gnt_idx;
  logic            gnt_any;
  logic [1:0]      tuser_q;
  logic            mode_q;
  logic [ID_W-1:0] id_q;
  logic [N_REQ-1:0] gnt_onehot, id_onehot;

  // Round-robin search: first valid requester at or after last_grant+1.
  // Iterating from the far end lets the nearest candidate overwrite.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % N_REQ;
      if (bus.req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = ID_W'(idx);
      end
    end
  end

  assign gnt_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx;
  assign id_onehot  = {{(N_REQ-1){1'b0}}, 1'b1} << id_q;
  assign wd_dec     = (wd == 16'd0) ? 16'd0 : wd - 16'd1;

  // Next-state, watchdog and fail-flag logic.
  always_comb begin
    state_nxt = state;
    wd_nxt    = wd;
    fail_nxt  = fail;
    unique case (state)
      IDLE: begin
        if (gnt_any) state_nxt = START;
      end
      START: begin
        wd_nxt    = 16'(PERM_WAIT);
        state_nxt = PERM;
      end
      PERM: begin
        wd_nxt = wd_dec;
        if (bus.core_done) begin
          wd_nxt    = 16'(DRAIN_WAIT);
          state_nxt = DRAIN;
        end else if (wd <= 16'd1) begin
          fail_nxt  = 1'b1;
          state_nxt = RELEASE;
        end
      end
      DRAIN: begin
        wd_nxt = wd_dec;
        if (bus.out_last) begin
          state_nxt = RELEASE;
        end else if (wd <= 16'd1) begin
          fail_nxt  = 1'b1;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        fail_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; req_ready is held off while in reset
  // because it is combinational on req_valid.
  always_comb begin
    bus.req_ready  = (state == IDLE && gnt_any && !ARESET) ? gnt_onehot : '0;
    bus.core_start = (state == START);
    bus.out_ready  = (state == DRAIN);
    bus.done       = (state == RELEASE && !fail) ? id_onehot : '0;
    bus.err        = (state == RELEASE &&  fail) ? id_onehot : '0;
    bus.busy       = (state != IDLE);
    bus.out_tuser  = tuser_q;
    bus.out_mode   = mode_q;
    bus.out_id     = id_q;
  end

  // State, watchdog and fail registers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state <= IDLE;
      wd    <= '0;
      fail  <= 1'b0;
    end else begin
      state <= state_nxt;
      wd    <= wd_nxt;
      fail  <= fail_nxt;
    end
  end

  // Job attributes latched at grant; owner remembered for round-robin.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      tuser_q    <= '0;
      mode_q     <= 1'b0;
      id_q       <= '0;
      last_grant <= ID_W'(N_REQ - 1);
    end else begin
      if (state == IDLE && gnt_any) begin
        tuser_q <= bus.req_tuser[2*int'(gnt_idx) +: 2];
        mode_q  <= bus.req_lite[gnt_idx];
        id_q    <= gnt_idx;
      end
      if (state == RELEASE) last_grant <= id_q;
    end
  end
endmodule

// File: tb/tb_sha3_job_sched.sv
// Directed bench for sha3_job_sched: a job table driven through a small
// core/serializer model, plus hand-written reset sequences.
module tb_sha3_job_sched;
  localparam int N  = 2;
  localparam int NV = 100000;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  always #5 ACLK = ~ACLK;

  sha3_job_sched_if #(.N_REQ(N)) bus();

  sha3_job_sched #(.N_REQ(N), .DATA_WIDTH(16), .PERM_WAIT(32)) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] valid;
    logic [3:0] tuser;
    logic [1:0] lite;
    logic       drop;
    logic       pre_rst;
    int d;
    int w;
    int sd;
    int sl;
    int g;
    int e;
    int end_off;
    int rdy;
    int tu;
    int md;
  } job_t;

  job_t jobs[9];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req_valid = '0;
    bus.req_tuser = '0;
    bus.req_lite  = '0;
    bus.core_done = 1'b0;
    bus.out_last  = 1'b0;
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    idle_inputs();
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
  endtask

  function automatic int idx_of(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Entered and left at 1 time unit after a rising edge.
  task automatic run_job(input job_t j, input int n);
    int cs, gcyc, gidx, rq_cnt, cs_cnt, rdy_cnt, fin_cnt, end_off;
    int fin_err, fin_idx, tu, md, id, unstable;
    bit granted, fin;
    cs = -1; gcyc = -1; gidx = -1; rq_cnt = 0; cs_cnt = 0; rdy_cnt = 0;
    fin_cnt = 0; end_off = -1; fin_err = -1; fin_idx = -1;
    tu = -1; md = -1; id = -1; unstable = 0; granted = 0; fin = 0;
    if (j.pre_rst) do_reset();
    for (int k = 0; k < 400 && !fin; k++) begin
      bus.req_valid = (granted && j.drop) ? 2'b00 : j.valid;
      bus.req_tuser = j.tuser;
      bus.req_lite  = j.lite;
      bus.core_done = (cs >= 0) && ((k - cs) == j.d || (k - cs) == j.sd);
      bus.out_last  = ((cs >= 0) && (k - cs) == j.sl) ||
                      (bus.out_ready && rdy_cnt == j.w - 1);
      @(negedge ACLK);
      if (|bus.req_ready) begin
        rq_cnt++;
        if (!granted) begin
          granted = 1;
          gcyc = k;
          gidx = idx_of(bus.req_ready);
        end
      end
      if (bus.core_start) begin
        cs_cnt++;
        if (cs < 0) begin
          cs = k;
          tu = int'(bus.out_tuser);
          md = int'(bus.out_mode);
          id = int'(bus.out_id);
        end
      end else if (cs >= 0) begin
        if (int'(bus.out_tuser) != tu || int'(bus.out_mode) != md ||
            int'(bus.out_id) != id) unstable = 1;
      end
      if (bus.out_ready) rdy_cnt++;
      if (|bus.done || |bus.err) begin
        fin_cnt++;
        fin = 1;
        end_off = k - cs;
        fin_err = |bus.err ? 1 : 0;
        fin_idx = |bus.err ? idx_of(bus.err) : idx_of(bus.done);
      end
      @(posedge ACLK);
      #1;
    end
    chk($sformatf("job%0d_finished", n), int'(fin), 1);
    chk($sformatf("job%0d_grant_idx", n), gidx, j.g);
    chk($sformatf("job%0d_grant_cycle", n), gcyc, 0);
    chk($sformatf("job%0d_start_latency", n), cs - gcyc, 1);
    chk($sformatf("job%0d_req_ready_pulses", n), rq_cnt, 1);
    chk($sformatf("job%0d_core_start_pulses", n), cs_cnt, 1);
    chk($sformatf("job%0d_end_offset", n), end_off, j.end_off);
    chk($sformatf("job%0d_out_ready_cycles", n), rdy_cnt, j.rdy);
    chk($sformatf("job%0d_err_flag", n), fin_err, j.e);
    chk($sformatf("job%0d_fin_idx", n), fin_idx, j.g);
    chk($sformatf("job%0d_fin_pulses", n), fin_cnt, 1);
    chk($sformatf("job%0d_out_tuser", n), tu, j.tu);
    chk($sformatf("job%0d_out_mode", n), md, j.md);
    chk($sformatf("job%0d_out_id", n), id, j.g);
    chk($sformatf("job%0d_attr_stable", n), unstable, 0);
  endtask

  initial begin
    int n;
    logic [11:0] outs;

    //          valid  tuser    lite   drp rst  d   w    sd  sl   g  e  end  rdy tu md
    jobs[0] = '{2'b01, 4'b0001, 2'b01, 0, 1, 24, 16,  NV, NV, 0, 0, 41,  16, 1, 1};
    jobs[1] = '{2'b11, 4'b1110, 2'b10, 0, 1,  5,  4,  NV, NV, 0, 0, 10,   4, 2, 0};
    jobs[2] = '{2'b11, 4'b1110, 2'b10, 0, 0,  3, 25,  NV, NV, 1, 0, 29,  25, 3, 1};
    jobs[3] = '{2'b11, 4'b1110, 2'b10, 0, 0,  1,  1,  NV, NV, 0, 0,  3,   1, 2, 0};
    jobs[4] = '{2'b11, 4'b1110, 2'b10, 0, 0,  8,  2,  NV, NV, 1, 0, 11,   2, 3, 1};
    jobs[5] = '{2'b10, 4'b0100, 2'b00, 0, 0, NV, 16,  NV, NV, 1, 1, 33,   0, 1, 0};
    jobs[6] = '{2'b01, 4'b0100, 2'b00, 0, 0, 10, 16,  NV,  2, 0, 0, 27,  16, 0, 0};
    jobs[7] = '{2'b01, 4'b0011, 2'b00, 0, 0,  4,  0,   7, NV, 0, 1, 113, 108, 3, 0};
    jobs[8] = '{2'b10, 4'b1000, 2'b00, 1, 0,  6, 100, NV, NV, 1, 0, 107, 100, 2, 0};

    // reset state, with requests pending to show req_ready stays low
    ARESET = 1'b1;
    idle_inputs();
    bus.req_valid = 2'b11;
    @(negedge ACLK);
    chk("rst_req_ready", int'(bus.req_ready), 0);
    chk("rst_core_start", int'(bus.core_start), 0);
    chk("rst_out_ready", int'(bus.out_ready), 0);
    chk("rst_out_tuser", int'(bus.out_tuser), 0);
    chk("rst_out_mode", int'(bus.out_mode), 0);
    chk("rst_out_id", int'(bus.out_id), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_busy", int'(bus.busy), 0);
    @(posedge ACLK);
    #1 ARESET = 1'b0;
    idle_inputs();

    for (int i = 0; i < 9; i++) run_job(jobs[i], i);

    // attributes hold their last values while idle
    idle_inputs();
    @(negedge ACLK);
    chk("idle_busy", int'(bus.busy), 0);
    chk("idle_hold_out_id", int'(bus.out_id), 1);
    chk("idle_hold_out_tuser", int'(bus.out_tuser), 2);

    // reset in the middle of DRAIN with requester 1 owning the job
    @(posedge ACLK);
    #1;
    do_reset();
    bus.req_valid = 2'b10;
    bus.core_done = 1'b1;
    n = 0;
    while (!bus.out_ready && n < 60) begin
      @(posedge ACLK);
      #1;
      n++;
    end
    chk("mid_drain_reached", int'(bus.out_ready), 1);
    chk("mid_drain_owner", int'(bus.out_id), 1);
    @(posedge ACLK);
    #1;
    @(posedge ACLK);
    #2 ARESET = 1'b1;
    #1;
    outs = {bus.req_ready, bus.core_start, bus.out_ready, bus.out_tuser,
            bus.out_mode, bus.out_id, bus.done, bus.err, bus.busy};
    chk("async_rst_outputs", int'(outs), 0);
    bus.core_done = 1'b0;
    bus.req_valid = 2'b00;
    n = 0;
    repeat (3) begin
      @(negedge ACLK);
      if (|bus.done || |bus.err) n++;
    end
    chk("rst_no_fin_pulse", n, 0);
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    bus.req_valid = 2'b11;
    @(negedge ACLK);
    chk("post_rst_grant", int'(bus.req_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
